// File: rtl/fp32_to_fp16_pipe_if.sv
// Beat-level handshake bundle for the FP32-to-FP16 converter.
// The master side produces FP32 beats and consumes FP16 results; the slave
// side is the converter itself.
interface fp32_to_fp16_pipe_if #(
    parameter int LANES = 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [32*LANES-1:0]    in_data;
    logic [1:0]             in_rm;
    logic                   out_valid;
    logic                   out_ready;
    logic [16*LANES-1:0]    out_data;
    logic [4*LANES-1:0]     out_flags;

    modport master (
        output in_valid,
        output in_data,
        output in_rm,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_flags
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_rm,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_flags
    );
endinterface

// File: rtl/fp32_to_fp16_pipe.sv
// Two-stage, multi-lane FP32 -> FP16 converter with IEEE-754 rounding.
// Stage 1 classifies each lane, rebiases the exponent and aligns the
// mantissa into a 10-bit field plus guard/sticky. Stage 2 rounds, packs
// and raises flags into the registered output. All lanes of a beat share
// one valid/ready handshake and one rounding mode, which travels with
// the beat.
module fp32_to_fp16_pipe #(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fp32_to_fp16_pipe_if.slave    bus
);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Per-lane state carried from the align stage to the round stage.
    // 'special' lanes (NaN/Inf/zero) already hold their final encoding.
    // 'big' marks an unbiased exponent already past the FP16 range.
    typedef struct packed {
        logic        sign;
        logic        special;
        logic [15:0] spec_data;
        logic        spec_inv;
        logic        big;
        logic        tiny;
        logic [4:0]  exp;
        logic [9:0]  mant;
        logic        guard;
        logic        sticky;
    } s1_lane_t;

    // Classify one FP32 operand and align it onto the FP16 grid.
    function automatic s1_lane_t classify_lane(input logic [31:0] x);
        s1_lane_t          r;
        logic [7:0]        ex;
        logic [22:0]       m;
        logic signed [9:0] e;
        logic [4:0]        amt;
        logic [33:0]       sh_v;
        r      = '0;
        r.sign = x[31];
        ex     = x[30:23];
        m      = x[22:0];
        // Rebias 127 -> 15 in a signed 10-bit field.
        e      = $signed({2'b00, ex}) - 10'sd112;
        // Subnormal alignment: shift {1,m} right by 14-e (14..24). Bits
        // [23:0] of the window are the shifted-out part.
        amt    = 5'(10'sd14 - e);
        sh_v   = 34'({1'b1, m, 24'd0} >> amt);
        if ((ex == 8'hFF) && (m != 23'd0)) begin
            // NaN: quiet bit forced, payload top bits kept.
            r.special   = 1'b1;
            r.spec_data = {x[31], 5'b11111, 1'b1, m[21:13]};
            r.spec_inv  = ~m[22];
        end else if (ex == 8'hFF) begin
            r.special   = 1'b1;
            r.spec_data = {x[31], 5'b11111, 10'd0};
        end else if ((ex == 8'h00) && (m == 23'd0)) begin
            r.special   = 1'b1;
            r.spec_data = {x[31], 15'd0};
        end else if (ex == 8'h00) begin
            // FP32 denormal: far below half the smallest FP16 step, so it
            // behaves exactly like a pure sticky bit.
            r.tiny   = 1'b1;
            r.sticky = 1'b1;
        end else if (e > 10'sd30) begin
            r.big    = 1'b1;
        end else if (e >= 10'sd1) begin
            r.exp    = e[4:0];
            r.mant   = m[22:13];
            r.guard  = m[12];
            r.sticky = |m[11:0];
        end else if (e >= -10'sd10) begin
            r.tiny   = 1'b1;
            r.mant   = sh_v[33:24];
            r.guard  = sh_v[23];
            r.sticky = |sh_v[22:0];
        end else begin
            r.tiny   = 1'b1;
            r.sticky = 1'b1;
        end
        return r;
    endfunction

    // Whether the rounding mode adds one ulp to the truncated magnitude.
    function automatic logic round_inc(input s1_lane_t l, input logic [1:0] rm);
        logic inexact;
        logic inc;
        inexact = l.guard | l.sticky;
        case (rm)
            RM_RNE:  inc = l.guard & (l.sticky | l.mant[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = inexact & l.sign;
            RM_RUP:  inc = inexact & ~l.sign;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // Saturation value on overflow: Inf when the mode rounds away from
    // zero for this sign, otherwise the largest finite magnitude.
    function automatic logic [15:0] overflow_value(input logic sign, input logic [1:0] rm);
        logic [15:0] v;
        case (rm)
            RM_RNE:  v = {sign, 15'h7C00};
            RM_RTZ:  v = {sign, 15'h7BFF};
            RM_RDN:  v = sign ? 16'hFC00 : 16'h7BFF;
            RM_RUP:  v = sign ? 16'hFBFF : 16'h7C00;
            default: v = {sign, 15'h7C00};
        endcase
        return v;
    endfunction

    // Round, pack and flag one lane; returns {data[15:0], flags[3:0]}.
    function automatic logic [19:0] round_lane(input s1_lane_t l, input logic [1:0] rm);
        logic        inexact;
        logic        inc_m;
        logic        inc_n;
        logic [15:0] sum_m;
        logic        ovf;
        logic [15:0] d;
        logic [3:0]  f;
        inexact = l.guard | l.sticky;
        inc_m   = round_inc(l, rm);
        inc_n   = round_inc(l, RM_RNE);
        // Adding into the packed {exp,mant} field lets a mantissa carry
        // bump the exponent and turns a subnormal 0x3FF+1 into min normal.
        sum_m   = {1'b0, l.exp, l.mant} + {15'd0, inc_m};
        // Overflow is judged on the nearest-rounded magnitude as well, so
        // anything at or above 65520 reports overflow in every mode.
        ovf     = l.big | (sum_m[15:10] >= 6'd31) |
                  (inc_n & (l.exp == 5'd30) & (l.mant == 10'h3FF));
        if (l.special) begin
            d = l.spec_data;
            f = {l.spec_inv, 3'b000};
        end else if (ovf) begin
            d = overflow_value(l.sign, rm);
            f = 4'b0101;
        end else begin
            d = {l.sign, sum_m[14:0]};
            f = {2'b00, l.tiny & inexact, inexact};
        end
        return {d, f};
    endfunction

    logic                   s1_valid_r;
    logic [1:0]             s1_rm_r;
    s1_lane_t [LANES-1:0]   s1_lane_r;
    s1_lane_t [LANES-1:0]   s1_lane_s;

    logic                   out_valid_r;
    logic [16*LANES-1:0]    out_data_r;
    logic [4*LANES-1:0]     out_flags_r;
    logic [16*LANES-1:0]    s2_data_s;
    logic [4*LANES-1:0]     s2_flags_s;

    logic                   s2_load_s;
    logic                   s1_adv_s;
    logic                   in_ready_s;

    // Stage-advance control: a stage loads when empty or when it drains.
    always_comb begin
        s2_load_s  = ~out_valid_r | bus.out_ready;
        s1_adv_s   = s1_valid_r & s2_load_s;
        in_ready_s = ~s1_valid_r | s1_adv_s;
    end

    // Align stage datapath, one independent slice per lane.
    always_comb begin
        s1_lane_s = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_lane_s[i] = classify_lane(bus.in_data[32*i +: 32]);
        end
    end

    // Round stage datapath, one independent slice per lane.
    always_comb begin
        s2_data_s  = '0;
        s2_flags_s = '0;
        for (int i = 0; i < LANES; i++) begin
            {s2_data_s[16*i +: 16], s2_flags_s[4*i +: 4]} = round_lane(s1_lane_r[i], s1_rm_r);
        end
    end

    // Align-stage register: captures the beat and its rounding mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_rm_r    <= 2'b00;
            s1_lane_r  <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_rm_r   <= bus.in_rm;
                s1_lane_r <= s1_lane_s;
            end
        end
    end

    // Output register: holds the result steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_flags_r <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r  <= s2_data_s;
                out_flags_r <= s2_flags_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_flags = out_flags_r;

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// Self-checking bench for fp32_to_fp16_pipe (4 lanes). A value-level
// reference model (scaled-integer rounding onto the FP16 grid) predicts
// every beat; a negedge monitor scoreboards accepted beats against outputs
// and checks output stability under backpressure.
module tb_fp32_to_fp16_pipe;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_to_fp16_pipe_if #(.LANES(LANES)) bus ();
    fp32_to_fp16_pipe #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [16*LANES-1:0] d;
        logic [4*LANES-1:0]  f;
    } exp_t;
    exp_t sb_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Place a magnitude quantised to qn * 2^qexp onto the FP16 encoding.
    function automatic void encode(input longint qn, input int qexp,
                                   output logic [14:0] mag, output bit ovf);
        longint n;
        int     qe;
        int     be;
        n = qn; qe = qexp; ovf = 1'b0; mag = 15'd0;
        if (n == 0) begin
            mag = 15'd0;
        end else if (qe == -24 && n < 1024) begin
            mag = 15'(n);
        end else begin
            if (n >= 2048) begin n = n / 2; qe = qe + 1; end
            be = qe + 25;
            if (be >= 31) ovf = 1'b1;
            else mag = 15'(longint'(be) * 1024 + (n - 1024));
        end
    endfunction

    // Reference: {fp16[15:0], flags[3:0]} from the value of the operand.
    function automatic logic [19:0] model_lane(input logic [31:0] x, input logic [1:0] rm);
        logic        s;
        logic [22:0] m;
        int          ex, e_unb, exp2, qexp, sh;
        longint      sig, q, rem, half;
        bit          nz, gt, eq, up_m, up_n, ovf_m, ovf_n, away;
        logic [14:0] mag_m, mag_n;
        s = x[31]; m = x[22:0]; ex = int'(x[30:23]);
        if (ex == 255) begin
            if (m != 23'd0) return {s, 5'h1F, 1'b1, m[21:13], ~m[22], 3'b000};
            return {s, 15'h7C00, 4'h0};
        end
        if (ex == 0 && m == 23'd0) return {s, 15'h0000, 4'h0};
        if (ex == 0) begin
            sig = longint'(m); exp2 = -149; e_unb = -127;
        end else begin
            sig = longint'(m) + (64'sd1 << 23); exp2 = ex - 150; e_unb = ex - 127;
        end
        // Quantum of the FP16 grid at this magnitude.
        qexp = (e_unb - 10 > -24) ? e_unb - 10 : -24;
        sh   = qexp - exp2;
        if (sh >= 40) begin
            q = 0; nz = 1'b1; gt = 1'b0; eq = 1'b0;
        end else begin
            q    = sig >> sh;
            rem  = sig & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
            nz = (rem != 0); gt = (rem > half); eq = (rem == half);
        end
        up_n = gt || (eq && q[0]);
        case (rm)
            2'd0:    up_m = up_n;
            2'd1:    up_m = 1'b0;
            2'd2:    up_m = nz && s;
            default: up_m = nz && !s;
        endcase
        encode(q + (up_m ? 1 : 0), qexp, mag_m, ovf_m);
        encode(q + (up_n ? 1 : 0), qexp, mag_n, ovf_n);
        if (ovf_m || ovf_n) begin
            away = (rm == 2'd0) || (rm == 2'd3 && !s) || (rm == 2'd2 && s);
            return {s, away ? 15'h7C00 : 15'h7BFF, 4'b0101};
        end
        return {s, mag_m, 1'b0, 1'b0, (e_unb < -14) && nz, nz};
    endfunction

    function automatic exp_t model_beat(input logic [32*LANES-1:0] data, input logic [1:0] rm);
        exp_t        e;
        logic [19:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = model_lane(data[32*i +: 32], rm);
            e.d[16*i +: 16] = r[19:4];
            e.f[4*i +: 4]   = r[3:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_fp32();
        logic [7:0]  ex;
        logic [22:0] m;
        int          sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       ex = 8'd0;
            1:       ex = 8'd255;
            2:       ex = 8'($urandom_range(96, 102));
            3, 4, 5: ex = 8'($urandom_range(101, 113));
            6, 7:    ex = 8'($urandom_range(140, 145));
            default: ex = 8'($urandom_range(100, 150));
        endcase
        m = 23'($urandom);
        if ($urandom_range(0, 3) == 0) m[12:0] = 13'h1000;
        if ($urandom_range(0, 7) == 0) m = 23'd0;
        return {1'($urandom), ex, m};
    endfunction

    function automatic logic [32*LANES-1:0] rand_beat();
        logic [32*LANES-1:0] d;
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = rand_fp32();
        return d;
    endfunction

    // Monitor: scoreboard push on accept, compare on output transfer,
    // stability while stalled. Runs on the inactive edge.
    logic                held_pend = 1'b0;
    logic [16*LANES-1:0] held_d;
    logic [4*LANES-1:0]  held_f;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                held_pend = 1'b0;
            end else begin
                if (held_pend) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall_data",  64'(bus.out_data), 64'(held_d));
                    chk("stall_flags", 64'(bus.out_flags), 64'(held_f));
                end
                if (bus.in_valid && bus.in_ready)
                    sb_q.push_back(model_beat(bus.in_data, bus.in_rm));
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.out_data), 64'd0);
                        if (bus.out_data == '0) chk("unexpected_beat_flag", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.d));
                        chk("out_flags", 64'(bus.out_flags), 64'(e.f));
                    end
                end
                held_pend = bus.out_valid && !bus.out_ready;
                held_d    = bus.out_data;
                held_f    = bus.out_flags;
            end
        end
    end

    task automatic send_beat(input logic [32*LANES-1:0] data, input logic [1:0] rm);
        int n;
        bit acc;
        n = 0; acc = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = data; bus.in_rm = rm;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic stream(input int nbeats, input int stall_pct, input int gap_pct);
        int idx, cyc;
        bit clear;
        idx = 0; cyc = 0; clear = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (clear) begin bus.in_valid = 1'b0; clear = 1'b0; end
            if ((idx >= nbeats && sb_q.size() == 0) || cyc > 20 * nbeats + 100) break;
            if (idx < nbeats && !bus.in_valid && $urandom_range(0, 99) >= gap_pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = rand_beat();
                bus.in_rm    = 2'($urandom_range(0, 3));
            end
            bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin idx++; clear = 1'b1; end
            cyc++;
        end
        chk("stream_count", 64'(idx), 64'(nbeats));
        chk("stream_drained", 64'(sb_q.size()), 64'd0);
        bus.out_ready = 1'b1;
    endtask

    // Directed vectors with hand-computed results (rm: 0 RNE 1 RTZ 2 RDN 3 RUP).
    localparam int NDIR = 18;
    logic [31:0] dir_x  [NDIR] = '{32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h3F800001,
                                   32'h3F800001, 32'h477FF000, 32'h477FF000, 32'hC7800000,
                                   32'h33800000, 32'h33000000, 32'h33000000, 32'h00000001,
                                   32'h7F800001, 32'hFFC00000, 32'h387FE000, 32'hFF800000,
                                   32'h80000000, 32'h80000001};
    logic [1:0]  dir_rm [NDIR] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd3,
                                   2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                                   2'd0, 2'd2};
    logic [19:0] dir_r  [NDIR] = '{{16'h3C00, 4'h0}, {16'h3C00, 4'h1}, {16'h3C02, 4'h1},
                                   {16'h3C01, 4'h1}, {16'h3C00, 4'h1}, {16'h7C00, 4'h5},
                                   {16'h7BFF, 4'h5}, {16'hFBFF, 4'h5}, {16'h0001, 4'h0},
                                   {16'h0000, 4'h3}, {16'h0001, 4'h3}, {16'h0001, 4'h3},
                                   {16'h7E00, 4'h8}, {16'hFE00, 4'h0}, {16'h0400, 4'h3},
                                   {16'hFC00, 4'h0}, {16'h8000, 4'h0}, {16'h8001, 4'h3}};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [32*LANES-1:0] d;
        int idx;
        bit clear;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_rm = 2'd0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_data",  64'(bus.out_data), 64'd0);
        chk("reset_out_flags", 64'(bus.out_flags), 64'd0);
        chk("reset_in_ready",  64'(bus.in_ready), 64'd1);

        // Pin the reference model to hand-computed results.
        for (int i = 0; i < NDIR; i++)
            chk($sformatf("model_pin_%0d", i), 64'(model_lane(dir_x[i], dir_rm[i])), 64'(dir_r[i]));

        // Latency: accepted beat appears exactly two cycles later.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = {LANES{32'h3F800000}}; bus.in_rm = 2'd0;
        @(negedge clk);
        chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_idle", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data", 64'(bus.out_data), 64'h3C00_3C00_3C00_3C00);
        drain();

        // Directed vectors on lane 0, random companions on other lanes.
        for (int i = 0; i < NDIR; i++) begin
            d = rand_beat();
            d[31:0] = dir_x[i];
            send_beat(d, dir_rm[i]);
        end
        drain();

        // Flow control: out_ready low for 5 cycles while streaming 6 beats.
        idx = 0; clear = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (clear) begin bus.in_valid = 1'b0; clear = 1'b0; end
            if (idx >= 6 && sb_q.size() == 0) break;
            bus.out_ready = (cyc >= 5);
            if (idx < 6 && !bus.in_valid) begin
                bus.in_valid = 1'b1; bus.in_data = rand_beat(); bus.in_rm = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) chk("fc_in_ready_low", 64'(bus.in_ready), 64'd0);
            if (cyc == 4) chk("fc_held_count", 64'(idx), 64'd2);
            if (bus.in_valid && bus.in_ready) begin idx++; clear = 1'b1; end
        end
        chk("fc_all_sent", 64'(idx), 64'd6);
        chk("fc_drained", 64'(sb_q.size()), 64'd0);
        bus.out_ready = 1'b1;

        // Reset mid-stream: in-flight beats discarded, nothing stale later.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = rand_beat(); bus.in_rm = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_out_data",  64'(bus.out_data), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Randomised streams: with backpressure, then full throughput.
        stream(200, 30, 20);
        stream(100, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp32_to_fp16_pipe.md
Name: fp32_to_fp16_pipe

Overview:
Pipelined, multi-lane FP32-to-FP16 converter with IEEE-754 rounding (four modes), exception flags and valid/ready flow control. It replaces combinational truncating conversion in datapaths that feed FP16 storage or compute. All LANES values in a beat share one handshake and one rounding mode. Fixed two-stage pipeline:
- S1: classify, rebias, align.
- S2: round, pack, flag.

Parameters:
LANES, 1, number of independent FP32 values converted per beat (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  converter accepts beat this cycle
in_data  in  32*LANES  FP32 operands; lane i at [32*i+31:32*i]
in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  16*LANES  FP16 results; lane i at [16*i+15:16*i]
out_flags  out  4*LANES  per lane {invalid, overflow, underflow, inexact} at [4*i+3:4*i]

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: S1/S2 valid cleared; out_valid=0, out_data=0, out_flags=0. Reset asserted mid-operation discards in-flight beats with no output.
- Transfers: in on in_valid&in_ready; out on out_valid&out_ready.
- Stage advance:
  - S2 may load when S2 is empty or out_ready=1.
  - S1 may load when S1 is empty or S1 advances.
  - in_ready = !S1_valid | S1_advance (combinational path from out_ready allowed).
- Latency: 2 cycles from accept to out_valid with no backpressure. Full throughput is 1 beat/cycle.
- Ordering: order preserved, no loss or duplication.
- Stall rules:
  - out_data and out_flags are stable while out_valid & !out_ready.
  - in_rm is captured with the beat and travels with it.
- Per-lane classification, evaluated in priority order:
  - NaN: output {s,11111,1,m[21:13]} (quiet bit forced). invalid=1 only for sNaN (exp=FF, m!=0, m[22]=0); other flags 0.
  - Inf: output {s,11111,0}; no flags.
  - Zero: output {s,15'b0}; no flags.
  - FP32 denormal: treat as nonzero value far below 2^-25. Result is {s,0} except RUP&!s gives 0x0001 and RDN&s gives 0x8001. Flags underflow=1, inexact=1.
  - Normal: e = exp-112, using a signed 10-bit intermediate.
- Normal path, alignment:
  - e>=1: keep m[22:13]; guard = m[12], sticky = |m[11:0].
  - -10<=e<=0: shift {1,m} right by (14-e). Guard and sticky are taken from the shifted-out bits.
  - e<-10: mantissa=0, guard=0, sticky=1.
- Normal path, rounding:
  - inexact = guard|sticky.
  - Increment by mode: RNE guard&(sticky|lsb); RTZ never; RUP inexact&!s; RDN inexact&s.
- Carry:
  - A mantissa carry increments the exponent.
  - A denormal rounding up to 0x400 becomes the min normal (exp=1).
- Overflow: post-round exp>=31, or e>30.
  - RNE: output ±Inf.
  - RTZ: output ±0x7BFF.
  - RUP: +Inf for s=0, 0xFBFF for s=1.
  - RDN: 0x7BFF for s=0, -Inf for s=1.
  - Flags overflow=1, inexact=1.
- Underflow: tininess is detected before rounding (e<1). underflow = tiny & inexact.
- Lanes: independent datapaths with no cross-lane interaction.

Test Plan:
- 0x3F800000, RNE, no backpressure: out 0x3C00, flags 0000, out_valid exactly 2 cycles after accept.
- Tie-to-even and directed rounding:
  - 0x3F801000 RNE: 0x3C00, flags 0001.
  - 0x3F803000 RNE: 0x3C02, flags 0001.
  - 0x3F800001 RUP: 0x3C01, flags 0001.
  - 0x3F800001 RTZ: 0x3C00.
- Overflow and exponent carry:
  - 0x477FF000 (65520) RNE: 0x7C00, flags 0101.
  - Same value RTZ: 0x7BFF, flags 0101.
  - 0xC7800000 RUP: 0xFBFF, flags 0101.
- Subnormal/underflow:
  - 0x33800000: 0x0001, flags 0000.
  - 0x33000000 RNE: 0x0000, flags 0011.
  - 0x33000000 RUP: 0x0001, flags 0011.
  - 0x00000001 RUP: 0x0001.
- NaN: 0x7F800001 gives 0x7E00 with flags 1000. 0xFFC00000 gives 0xFE00 with flags 0000.
- Flow control (LANES=4):
  - Stream 6 random beats while holding out_ready=0 for 5 cycles. in_ready must drop after 2 beats are held, outputs stay stable, and all 6 arrive in order against the reference model.
  - Assert rst mid-stream: out_valid=0 on the next cycle and no stale beats appear afterward.
